// File: rtl/pipe_stage_buf_if.sv
// Valid/ready/data bundle for one side of a pipeline stage boundary.
// The master drives Valid/Data and the slave drives Ready.
interface pipe_stage_buf_if #(
  parameter int WIDTH = 32
);
  logic             Valid;
  logic             Ready;
  logic [WIDTH-1:0] Data;

  modport master (output Valid, output Data, input Ready);
  modport slave  (input Valid, input Data, output Ready);
endinterface

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline register between processor stages: a DEPTH-slot circular buffer
// with valid/ready handshake, flush and a bubble value presented while empty.
module pipe_stage_buf #(
  parameter int               WIDTH        = 32,
  parameter int               DEPTH        = 2,
  parameter logic [WIDTH-1:0] BUBBLE_VALUE = WIDTH'(32'h00000013),
  parameter int               CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Flush,
  pipe_stage_buf_if.slave  In,
  pipe_stage_buf_if.master Out,
  output logic [CNT_W-1:0] Count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] slot_reg [DEPTH];
  logic [DEPTH-1:0] slot_we;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_next;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             in_ready;
  logic             out_valid;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head_data;

  // Pointers wrap by comparison so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  assign out_valid = (count_reg != '0);
  assign push      = In.Valid & in_ready & ~Flush;
  assign pop       = out_valid & Out.Ready & ~Flush;

  generate
    if (DEPTH == 1) begin : g_single
      // A lone slot may be refilled in the cycle it drains.
      assign in_ready  = (count_reg == '0) | Out.Ready;
      assign head_data = slot_reg[0];
    end else begin : g_multi
      // Ready depends on held state only, breaking the Out.Ready -> In.Ready path.
      assign in_ready  = (count_reg < CNT_W'(DEPTH));
      assign head_data = slot_reg[rd_ptr_reg];
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
      assign slot_we[gi] = push & (wr_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  always_ff @(posedge CLK) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_we[i]) begin
        slot_reg[i] <= In.Data;
      end
    end
  end

  always_comb begin
    count_next  = count_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    if (Flush) begin
      count_next  = '0;
      rd_ptr_next = '0;
      wr_ptr_next = '0;
    end else begin
      if (push) begin
        wr_ptr_next = ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_next = ptr_inc(rd_ptr_reg);
      end
      if (push && !pop) begin
        count_next = count_reg + 1'b1;
      end else if (pop && !push) begin
        count_next = count_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
    end else begin
      count_reg  <= count_next;
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
    end
  end

  assign In.Ready  = in_ready;
  assign Out.Valid = out_valid;
  assign Out.Data  = out_valid ? head_data : BUBBLE_VALUE;
  assign Count     = count_reg;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: DEPTH 1, 2 and 3 instances side by side, each
// shadowed by a queue model, plus directed scenarios with literal expectations.
module tb_pipe_stage_buf;

  localparam logic [31:0] BUB = 32'h00000013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  in_valid;
  logic [2:0]  out_ready;
  logic [2:0]  flush;
  logic [31:0] in_data [3];

  logic [2:0]  o_valid;
  logic [2:0]  o_inrdy;
  logic [31:0] o_data  [3];
  logic [3:0]  o_count [3];
  logic [3:0]  m_count [3];
  logic [31:0] m_head  [3];

  int total = 0;
  int bad = 0;
  bit checking = 1'b0;
  logic [31:0] pops1 [$];
  logic [31:0] pops2 [$];

  // Instance gi has DEPTH gi+1.
  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int DEP = gi + 1;
    localparam int CW  = $clog2(DEP + 1);

    pipe_stage_buf_if #(.WIDTH(32)) up_if ();
    pipe_stage_buf_if #(.WIDTH(32)) dn_if ();
    logic [CW-1:0] cnt;
    logic [31:0]   q [$];
    int            e_cnt = 0;
    logic [31:0]   e_head = BUB;

    assign up_if.Valid = in_valid[gi];
    assign up_if.Data  = in_data[gi];
    assign dn_if.Ready = out_ready[gi];

    pipe_stage_buf #(
      .WIDTH(32), .DEPTH(DEP), .BUBBLE_VALUE(BUB)
    ) u_dut (
      .CLK(clk), .RST(rst_n), .Flush(flush[gi]),
      .In(up_if), .Out(dn_if), .Count(cnt)
    );

    assign o_valid[gi] = dn_if.Valid;
    assign o_data[gi]  = dn_if.Data;
    assign o_inrdy[gi] = up_if.Ready;
    assign o_count[gi] = 4'(cnt);
    assign m_count[gi] = 4'(e_cnt);
    assign m_head[gi]  = e_head;

    // Queue model: what is held, in arrival order.
    always @(posedge clk) begin
      int sz;
      bit pop_m;
      bit push_m;
      sz = q.size();
      if (!rst_n || flush[gi]) begin
        q.delete();
      end else begin
        pop_m  = (sz != 0) && out_ready[gi];
        push_m = in_valid[gi] && ((DEP == 1) ? (sz == 0 || out_ready[gi]) : (sz < DEP));
        if (pop_m) void'(q.pop_front());
        if (push_m) q.push_back(in_data[gi]);
      end
      e_cnt  <= q.size();
      e_head <= (q.size() != 0) ? q[0] : BUB;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Compare every instance against its model, note pops, then advance one clock.
  task automatic tick();
    logic exp_rdy;
    #1;
    if (checking) begin
      for (int k = 0; k < 3; k++) begin
        exp_rdy = (k == 0) ? (m_count[k] == 0 || out_ready[k]) : (m_count[k] < 4'(k + 1));
        chk($sformatf("d%0d_valid", k + 1), {31'd0, o_valid[k]}, {31'd0, m_count[k] != 0});
        chk($sformatf("d%0d_data", k + 1), o_data[k], m_head[k]);
        chk($sformatf("d%0d_count", k + 1), {28'd0, o_count[k]}, {28'd0, m_count[k]});
        chk($sformatf("d%0d_in_ready", k + 1), {31'd0, o_inrdy[k]}, {31'd0, exp_rdy});
      end
    end
    if (rst_n && o_valid[1] && out_ready[1] && !flush[1]) pops1.push_back(o_data[1]);
    if (rst_n && o_valid[2] && out_ready[2] && !flush[2]) pops2.push_back(o_data[2]);
    @(posedge clk);
    @(negedge clk);
    $display("t=%0t d1 cnt=%0d d2 cnt=%0d data=%h d3 cnt=%0d data=%h",
             $time, o_count[0], o_count[1], o_data[1], o_count[2], o_data[2]);
  endtask

  initial begin
    int v;
    int n;
    bit accept;
    logic [31:0] seed;
    seed = 32'hC0FFEE11;
    rst_n = 1'b0;
    in_valid = '0;
    out_ready = '0;
    flush = '0;
    for (int k = 0; k < 3; k++) in_data[k] = '0;

    // Reset then idle
    tick();
    checking = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    chk("reset_valid", {31'd0, o_valid[1]}, 32'd0);
    chk("reset_data", o_data[1], 32'h00000013);
    chk("reset_count", {28'd0, o_count[1]}, 32'd0);
    chk("reset_in_ready", {31'd0, o_inrdy[1]}, 32'd1);

    // Streaming through DEPTH=2
    pops1.delete();
    out_ready[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid[1] = 1'b1;
      in_data[1] = 32'hA0 + i;
      tick();
      chk("stream_data", o_data[1], 32'hA0 + i);
      chk("stream_count", {28'd0, o_count[1]}, 32'd1);
      chk("stream_in_ready", {31'd0, o_inrdy[1]}, 32'd1);
    end
    in_valid[1] = 1'b0;
    tick();
    chk("stream_drained", {28'd0, o_count[1]}, 32'd0);

    // Backpressure until full, then one pop
    pops1.delete();
    out_ready[1] = 1'b0;
    in_valid[1] = 1'b1;
    in_data[1] = 32'h11;
    tick();
    in_data[1] = 32'h22;
    tick();
    in_data[1] = 32'h33;
    chk("full_in_ready", {31'd0, o_inrdy[1]}, 32'd0);
    tick();
    chk("full_count", {28'd0, o_count[1]}, 32'd2);
    chk("full_head", o_data[1], 32'h11);
    out_ready[1] = 1'b1;
    tick();
    chk("after_pop_count", {28'd0, o_count[1]}, 32'd1);
    chk("after_pop_data", o_data[1], 32'h22);
    chk("after_pop_in_ready", {31'd0, o_inrdy[1]}, 32'd1);
    out_ready[1] = 1'b0;
    tick();
    chk("accept_33_count", {28'd0, o_count[1]}, 32'd2);
    in_valid[1] = 1'b0;
    out_ready[1] = 1'b1;
    tick();
    tick();
    chk("bp_pop_n", pops1.size(), 32'd3);
    if (pops1.size() == 3) begin
      chk("bp_order0", pops1[0], 32'h11);
      chk("bp_order1", pops1[1], 32'h22);
      chk("bp_order2", pops1[2], 32'h33);
    end
    out_ready[1] = 1'b0;

    // Wrap-around through DEPTH=3 with pseudo-random backpressure
    pops2.delete();
    v = 0;
    n = 0;
    while ((v < 10 || o_count[2] != 0) && n < 200) begin
      in_valid[2] = (v < 10);
      in_data[2] = v;
      seed = seed * 32'd1664525 + 32'd1013904223;
      out_ready[2] = seed[16];
      accept = (v < 10) && o_inrdy[2];
      tick();
      if (accept) v++;
      n++;
    end
    in_valid[2] = 1'b0;
    out_ready[2] = 1'b0;
    chk("wrap_in_budget", {31'd0, n < 200}, 32'd1);
    chk("wrap_pop_n", pops2.size(), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < pops2.size()) chk($sformatf("wrap_order%0d", i), pops2[i], i);
    end

    // Flush a full DEPTH=2 buffer with a pending offer
    in_valid[1] = 1'b1;
    in_data[1] = 32'h55;
    tick();
    in_data[1] = 32'h66;
    tick();
    chk("pre_flush_count", {28'd0, o_count[1]}, 32'd2);
    flush[1] = 1'b1;
    in_data[1] = 32'h77;
    tick();
    chk("flush_count", {28'd0, o_count[1]}, 32'd0);
    chk("flush_valid", {31'd0, o_valid[1]}, 32'd0);
    chk("flush_data", o_data[1], BUB);
    flush[1] = 1'b0;
    in_valid[1] = 1'b0;
    tick();
    chk("flush_77_dropped", {28'd0, o_count[1]}, 32'd0);

    // DEPTH=1 pass-through replacement, then reset mid-operation
    out_ready[0] = 1'b0;
    in_valid[0] = 1'b1;
    in_data[0] = 32'hAA;
    tick();
    chk("d1_fill_data", o_data[0], 32'hAA);
    #1;
    chk("d1_full_in_ready", {31'd0, o_inrdy[0]}, 32'd0);
    out_ready[0] = 1'b1;
    in_data[0] = 32'hBB;
    #1;
    chk("d1_pass_in_ready", {31'd0, o_inrdy[0]}, 32'd1);
    tick();
    chk("d1_pass_data", o_data[0], 32'hBB);
    chk("d1_pass_count", {28'd0, o_count[0]}, 32'd1);
    rst_n = 1'b0;
    in_data[0] = 32'hCC;
    tick();
    chk("d1_reset_count", {28'd0, o_count[0]}, 32'd0);
    chk("d1_reset_data", o_data[0], BUB);
    rst_n = 1'b1;
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b0;
    tick();
    chk("d1_push_lost", {28'd0, o_count[0]}, 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised elastic pipeline register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generalises the fixed stall/flush stage register to:
  - a valid/ready handshake,
  - configurable payload width,
  - configurable buffer depth (1 = plain pipeline register, ≥2 = skid buffer/small FIFO),
  - a programmable bubble value driven while empty or flushed.
- The hazard unit drives Flush; the downstream stage drives Out_Ready.

Parameters:
- WIDTH, 32, payload width in bits (≥1).
- DEPTH, 2, number of storage slots (1..8).
- BUBBLE_VALUE, 32'h00000013, Out_Data value when no valid entry (default: NOP addi x0,x0,0). Width WIDTH.
- CNT_W, $clog2(DEPTH+1), width of the Count output.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  synchronous reset, active-low.
- Flush  input  1  discard all held entries and the current input this cycle.
- In_Valid  input  1  upstream has a payload on In_Data.
- In_Ready  output  1  buffer can accept In_Data this cycle.
- In_Data  input  WIDTH  upstream payload.
- Out_Valid  output  1  Out_Data holds a valid entry.
- Out_Ready  input  1  downstream consumes Out_Data this cycle.
- Out_Data  output  WIDTH  head entry, or BUBBLE_VALUE when empty.
- Count  output  CNT_W  number of valid entries held.

Behaviour:
- Reset (RST==0 at posedge):
  - Count=0, Out_Valid=0, Out_Data=BUBBLE_VALUE.
  - Read and write pointers = 0.
  - Storage contents don't-care.
  - Reset overrides Flush and any handshake in the same cycle.
- Push = In_Valid & In_Ready & ~Flush.
- Pop = Out_Valid & Out_Ready & ~Flush.
- Storage is a circular buffer of DEPTH slots:
  - write pointer advances on push; read pointer advances on pop.
  - both wrap modulo DEPTH (DEPTH need not be a power of two; wrap by compare-to-DEPTH-1).
- Count update at posedge: Count += push − pop. Simultaneous push and pop leaves Count unchanged.
- Out_Valid = (Count != 0). Out_Data = slot[rd_ptr] when Out_Valid, else BUBBLE_VALUE.
  - Both are driven from registered state only; no combinational path from In_* to Out_*.
- Latency: a payload accepted at edge N appears on Out_Data after edge N, provided all earlier entries have popped.
- In_Ready:
  - DEPTH==1: In_Ready = (Count==0) | Out_Ready. Pass-through replacement, so full throughput with a single slot.
  - DEPTH≥2: In_Ready = (Count < DEPTH). Registered-state only; Out_Ready does not reach In_Ready (timing break).
  - DEPTH≥2 full (Count==DEPTH): In_Ready=0 even if Out_Ready=1. The pop completes; the push is refused and must be held by upstream.
- In_Ready is asserted regardless of Flush. A handshake during Flush is still dropped, and upstream treats it as discarded.
- Flush (RST==1, Flush==1) at posedge:
  - Count→0, both pointers→0.
  - Next-cycle Out_Valid=0, Out_Data=BUBBLE_VALUE.
  - The In_Data offered in the flush cycle is not stored.
- Empty with Out_Ready=1: no pop, no change.
- Push when empty: data visible next cycle. There is no same-cycle bypass.
- In_Valid with In_Ready low: upstream must hold In_Valid/In_Data stable until accepted, except across a Flush.
- Out_Valid, once asserted, stays asserted with stable Out_Data until popped or flushed.
- Assertions the verifier checks:
  - Count ≤ DEPTH.
  - No push when Count==DEPTH.
  - Out_Data==BUBBLE_VALUE whenever Out_Valid==0.

Test Plan:
- Reset then idle:
  - Stimulus: RST=0 for 2 cycles, then RST=1, In_Valid=0.
  - Response: Out_Valid=0, Out_Data=32'h00000013, Count=0, In_Ready=1.
- Streaming, DEPTH=2:
  - Stimulus: push 0xA0,0xA1,0xA2 on consecutive cycles with Out_Ready=1.
  - Response: Out_Data shows 0xA0,0xA1,0xA2 one cycle after each push; Count stays 1; In_Ready stays 1.
- Backpressure/full, DEPTH=2:
  - Stimulus: Out_Ready=0, push 0x11,0x22, offer 0x33.
  - Response: Count=2, In_Ready=0, 0x33 refused.
  - Then Out_Ready=1 for one cycle: 0x11 popped, Count=1, Out_Data=0x22, In_Ready=1 next cycle, 0x33 accepted after that. Order 0x11,0x22,0x33 preserved.
- Wrap-around, DEPTH=3:
  - Stimulus: 10 pushes of values 0..9 with random Out_Ready (seed fixed).
  - Response: outputs exactly 0..9 in order; pointers wrap through slot 2→0 at least three times.
- Flush mid-stream, DEPTH=2:
  - Stimulus: Count=2 (0x55,0x66), assert Flush while In_Valid=1 with 0x77.
  - Response: next cycle Count=0, Out_Valid=0, Out_Data=BUBBLE_VALUE; 0x77 not stored.
- DEPTH=1 pass-through and reset mid-operation:
  - Stimulus: full single slot, Out_Ready=1, In_Valid=1 with 0xBB.
  - Response: pop and push in the same cycle, Out_Data=0xBB next cycle, Count=1.
  - Then RST=0 coinciding with Flush=0 and a push: Count=0, push lost.
